// File: rtl/pcie_read_engine_pkg.sv
// Shared types and width helpers for the multi-channel PCIe RAM read engine.
package pcie_rd_pkg;

    localparam int CH_W_MAX = 3;

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_ISSUE = 2'd1,
        CH_DRAIN = 2'd2
    } ch_state_e;

    typedef struct packed {
        logic [CH_W_MAX-1:0] ch;
        logic                last;
    } rd_tag_t;

    localparam int TAG_W = $bits(rd_tag_t);

    // Channel-id width, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pcie_read_engine_fifo.sv
// Synchronous FIFO with registered storage and occupancy count; output is
// forced to zero while empty so downstream never sees stale entries.
module rd_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             empty, full, do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i & ~empty;
    // A simultaneous pop makes room, so a push on a full FIFO is still taken.
    assign do_push = push_i & (~full | do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_data_o = empty ? '0 : mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/pcie_read_engine.sv
// Multi-channel RAM read engine: per-channel descriptor FSMs, round-robin
// issue with credit flow control, in-order return tagging and output stream.
module pcie_read_engine
    import pcie_rd_pkg::*;
#(
    parameter  int DATA_W     = 32,
    parameter  int ADDR_W     = 11,
    parameter  int NUM_CH     = 2,
    parameter  int FIFO_DEPTH = 4,
    parameter  int LEN_W      = ADDR_W + 1,
    localparam int CH_W       = id_width(NUM_CH)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic [NUM_CH-1:0]        ch_start_i,
    input  logic [NUM_CH*ADDR_W-1:0] ch_base_i,
    input  logic [NUM_CH*LEN_W-1:0]  ch_len_i,
    output logic [NUM_CH-1:0]        ch_busy_o,
    output logic [NUM_CH-1:0]        ch_done_o,
    output logic                     ram_rd_en_o,
    output logic [ADDR_W-1:0]        ram_addr_o,
    input  logic [DATA_W-1:0]        ram_data_i,
    input  logic                     ram_valid_i,
    output logic [DATA_W-1:0]        out_data_o,
    output logic [CH_W-1:0]          out_ch_o,
    output logic                     out_last_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic                     err_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    ch_state_e          state_q [NUM_CH];
    logic [ADDR_W-1:0]  addr_q  [NUM_CH];
    logic [LEN_W-1:0]   rem_q   [NUM_CH];
    logic [NUM_CH-1:0]  done_q;
    logic [CH_W-1:0]    rr_ptr_q;
    logic               err_q;

    logic [NUM_CH-1:0]  issue_req;
    logic [CH_W-1:0]    grant_ch, idx;
    logic               grant_vld, grant_last, credit_ok, issue;
    logic [CNT_W-1:0]   outstanding, fifo_count;
    logic               ret_push, out_accept, tag_unused;
    rd_tag_t            issue_tag, out_tag;
    logic [TAG_W-1:0]   ret_tag;
    logic [DATA_W+TAG_W-1:0] out_word;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) issue_req[i] = (state_q[i] == CH_ISSUE);
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        idx       = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = CH_W'((int'(rr_ptr_q) + k) % NUM_CH);
            if (!grant_vld && issue_req[idx]) begin
                grant_vld = 1'b1;
                grant_ch  = idx;
            end
        end
    end

    // Reads in flight plus words already buffered must fit in the return FIFO.
    assign credit_ok  = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CNT_W + 1)'(FIFO_DEPTH);
    assign issue      = enable_i & credit_ok & grant_vld;
    assign grant_last = (rem_q[grant_ch] == LEN_W'(1));

    assign issue_tag.ch   = CH_W_MAX'(grant_ch);
    assign issue_tag.last = grant_last;

    assign ram_rd_en_o = issue;
    assign ram_addr_o  = issue ? addr_q[grant_ch] : '0;

    assign ret_push   = ram_valid_i & (outstanding != '0);
    assign out_valid_o = (fifo_count != '0);
    assign out_accept = out_valid_o & out_ready_i;

    rd_sync_fifo #(.WIDTH(TAG_W), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (issue),
        .push_data_i (issue_tag),
        .pop_i       (ret_push),
        .pop_data_o  (ret_tag),
        .count_o     (outstanding)
    );

    rd_sync_fifo #(.WIDTH(DATA_W + TAG_W), .DEPTH(FIFO_DEPTH)) u_data_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (ret_push),
        .push_data_i ({ram_data_i, ret_tag}),
        .pop_i       (out_accept),
        .pop_data_o  (out_word),
        .count_o     (fifo_count)
    );

    assign out_tag    = rd_tag_t'(out_word[TAG_W-1:0]);
    assign out_data_o = out_word[DATA_W+TAG_W-1:TAG_W];
    assign out_ch_o   = out_tag.ch[CH_W-1:0];
    assign out_last_o = out_tag.last;
    assign tag_unused = ^out_tag.ch;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= CH_IDLE;
                addr_q[i]  <= '0;
                rem_q[i]   <= '0;
            end
            done_q   <= '0;
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            done_q <= '0;
            if (issue) rr_ptr_q <= (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + CH_W'(1);
            if (ram_valid_i && outstanding == '0) err_q <= 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                case (state_q[i])
                    CH_IDLE: if (ch_start_i[i]) begin
                        if (ch_len_i[i*LEN_W +: LEN_W] == '0) begin
                            done_q[i] <= 1'b1;
                        end else begin
                            state_q[i] <= CH_ISSUE;
                            addr_q[i]  <= ch_base_i[i*ADDR_W +: ADDR_W];
                            rem_q[i]   <= ch_len_i[i*LEN_W +: LEN_W];
                        end
                    end
                    CH_ISSUE: if (issue && grant_ch == CH_W'(i)) begin
                        addr_q[i] <= addr_q[i] + ADDR_W'(1);
                        rem_q[i]  <= rem_q[i] - LEN_W'(1);
                        if (rem_q[i] == LEN_W'(1)) state_q[i] <= CH_DRAIN;
                    end
                    CH_DRAIN: if (out_accept && out_last_o && out_ch_o == CH_W'(i)) begin
                        state_q[i] <= CH_IDLE;
                        done_q[i]  <= 1'b1;
                    end
                    default: state_q[i] <= CH_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) ch_busy_o[i] = (state_q[i] != CH_IDLE);
    end

    assign ch_done_o = done_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_pcie_read_engine.sv
// Scoreboard bench for pcie_read_engine: stimulus queues expected addresses and
// words, a RAM model and an output monitor pop and compare independently.
module tb_pcie_read_engine;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 11;
    localparam int NUM_CH = 2;
    localparam int LEN_W  = 12;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     enable = 1'b0;
    logic [NUM_CH-1:0]        ch_start = '0;
    logic [NUM_CH*ADDR_W-1:0] ch_base = '0;
    logic [NUM_CH*LEN_W-1:0]  ch_len = '0;
    logic [NUM_CH-1:0]        ch_busy, ch_done;
    logic                     ram_rd_en;
    logic [ADDR_W-1:0]        ram_addr;
    logic [DATA_W-1:0]        ram_data = '0;
    logic                     ram_valid = 1'b0;
    logic [DATA_W-1:0]        out_data;
    logic [0:0]               out_ch;
    logic                     out_last, out_valid;
    logic                     out_ready = 1'b1;
    logic                     err;

    pcie_read_engine dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .enable_i    (enable),
        .ch_start_i  (ch_start),
        .ch_base_i   (ch_base),
        .ch_len_i    (ch_len),
        .ch_busy_o   (ch_busy),
        .ch_done_o   (ch_done),
        .ram_rd_en_o (ram_rd_en),
        .ram_addr_o  (ram_addr),
        .ram_data_i  (ram_data),
        .ram_valid_i (ram_valid),
        .out_data_o  (out_data),
        .out_ch_o    (out_ch),
        .out_last_o  (out_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_t;

    exp_t              exp_q [NUM_CH][$];
    logic [ADDR_W-1:0] exp_addr [$];
    logic [ADDR_W-1:0] pend_addr [$];
    int                pend_due [$];
    int                n_vec = 0, n_err = 0, cyc = 0, lat = 1, n_issue = 0;
    logic              inject = 1'b0;
    logic [NUM_CH-1:0] len0_mask = '0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
        return 32'hC0DE_0000 | {21'd0, a};
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_desc(input int ch, input logic [ADDR_W-1:0] base, input int len, input bit with_addr);
        logic [ADDR_W-1:0] a;
        exp_t e;
        for (int k = 0; k < len; k++) begin
            a = base + ADDR_W'(k);
            if (with_addr) exp_addr.push_back(a);
            e.data = ram_word(a);
            e.last = (k == len - 1);
            exp_q[ch].push_back(e);
        end
    endtask

    task automatic set_desc(input int ch, input logic [ADDR_W-1:0] base, input int len);
        ch_base[ch*ADDR_W +: ADDR_W] = base;
        ch_len[ch*LEN_W +: LEN_W]    = LEN_W'(len);
    endtask

    task automatic pulse(input logic [NUM_CH-1:0] mask);
        @(negedge clk);
        ch_start = mask;
        for (int i = 0; i < NUM_CH; i++)
            if (mask[i] && !ch_busy[i] && ch_len[i*LEN_W +: LEN_W] == '0) len0_mask[i] = 1'b1;
        @(negedge clk);
        ch_start = '0;
    endtask

    task automatic wait_idle(input string name);
        int  k;
        bit  idle;
        k = 0;
        idle = 1'b0;
        while (!idle && k < 300) begin
            tick();
            k++;
            idle = (ch_busy == '0) && !out_valid && exp_addr.size() == 0 &&
                   exp_q[0].size() == 0 && exp_q[1].size() == 0;
        end
        chk({name, "_idle"}, 64'(idle), 64'd1);
        repeat (2) tick();
    endtask

    // Clock-cycle counter.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // RAM model: checks each read address, returns data in order after lat cycles.
    initial forever begin
        tick();
        if (rst) begin
            pend_addr.delete();
            pend_due.delete();
            ram_valid = 1'b0;
            ram_data  = '0;
        end else begin
            if (ram_rd_en) begin
                n_issue++;
                if (exp_addr.size() == 0) chk("unexpected_read", 64'(ram_addr), 64'hFFFF);
                else chk("ram_addr", 64'(ram_addr), 64'(exp_addr.pop_front()));
                pend_addr.push_back(ram_addr);
                pend_due.push_back(cyc + lat);
            end
            if (inject) begin
                ram_valid = 1'b1;
                ram_data  = 32'hDEAD_BEEF;
                inject    = 1'b0;
            end else if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
                ram_valid = 1'b1;
                ram_data  = ram_word(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                ram_valid = 1'b0;
            end
        end
    end

    // Output monitor: word scoreboard, hold-stable check, ch_done timing.
    initial begin
        logic [NUM_CH-1:0] pend_done, nd;
        logic              hold_pend;
        logic [DATA_W-1:0] hold_data;
        logic              hold_ch, hold_last;
        exp_t              e;
        pend_done = '0;
        hold_pend = 1'b0;
        hold_data = '0;
        hold_ch   = 1'b0;
        hold_last = 1'b0;
        forever begin
            tick();
            if (rst) begin
                pend_done = '0;
                hold_pend = 1'b0;
            end else begin
                chk("ch_done", 64'(ch_done), 64'(pend_done));
                nd = len0_mask;
                len0_mask = '0;
                if (hold_pend) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_word", {31'd0, out_last, out_ch, out_data}, {31'd0, hold_last, hold_ch, hold_data});
                end
                hold_pend = out_valid && !out_ready;
                hold_data = out_data;
                hold_ch   = out_ch;
                hold_last = out_last;
                if (out_valid && out_ready) begin
                    if (exp_q[int'(out_ch)].size() == 0) begin
                        chk("unexpected_word", 64'(out_data), 64'hFFFF_FFFF_FFFF);
                    end else begin
                        e = exp_q[int'(out_ch)].pop_front();
                        chk("out_data", 64'(out_data), 64'(e.data));
                        chk("out_last", 64'(out_last), 64'(e.last));
                    end
                    if (out_last) nd[out_ch] = 1'b1;
                end
                pend_done = nd;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_issue;

        // Reset values
        tick();
        tick();
        chk("rst_ram_rd_en", 64'(ram_rd_en), 64'd0);
        chk("rst_ram_addr",  64'(ram_addr),  64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_ch",    64'(out_ch),    64'd0);
        chk("rst_out_last",  64'(out_last),  64'd0);
        chk("rst_ch_busy",   64'(ch_busy),   64'd0);
        chk("rst_ch_done",   64'(ch_done),   64'd0);
        chk("rst_err",       64'(err),       64'd0);
        @(negedge clk);
        rst    = 1'b0;
        enable = 1'b1;
        repeat (2) tick();

        // Single channel, base 0x010, len 4, latency 2
        lat = 2;
        set_desc(0, 11'h010, 4);
        push_desc(0, 11'h010, 4, 1'b1);
        pulse(2'b01);
        #1;
        chk("t1_busy", 64'(ch_busy), 64'b01);
        wait_idle("t1");

        // Both channels together; RR pointer sits at ch1 after t1
        set_desc(0, 11'h100, 3);
        set_desc(1, 11'h200, 3);
        push_desc(0, 11'h100, 3, 1'b0);
        push_desc(1, 11'h200, 3, 1'b0);
        exp_addr.push_back(11'h200);
        exp_addr.push_back(11'h100);
        exp_addr.push_back(11'h201);
        exp_addr.push_back(11'h101);
        exp_addr.push_back(11'h202);
        exp_addr.push_back(11'h102);
        pulse(2'b11);
        wait_idle("t2");

        // Address wrap at the top of RAM
        lat = 1;
        set_desc(1, 11'h7FE, 4);
        push_desc(1, 11'h7FE, 4, 1'b1);
        pulse(2'b10);
        wait_idle("t3");

        // Backpressure: only FIFO_DEPTH reads may issue
        @(negedge clk);
        out_ready = 1'b0;
        set_desc(0, 11'h040, 10);
        push_desc(0, 11'h040, 10, 1'b1);
        base_issue = n_issue;
        pulse(2'b01);
        repeat (20) tick();
        chk("stall_issues", 64'(n_issue - base_issue), 64'd4);
        chk("stall_rd_en", 64'(ram_rd_en), 64'd0);
        chk("stall_valid", 64'(out_valid), 64'd1);
        set_desc(0, 11'h500, 1);
        pulse(2'b01);
        @(negedge clk);
        out_ready = 1'b1;
        wait_idle("t4");
        chk("t4_total_issues", 64'(n_issue - base_issue), 64'd10);

        // Stray return while idle
        @(negedge clk);
        inject = 1'b1;
        repeat (3) tick();
        chk("err_set", 64'(err), 64'd1);
        chk("err_no_valid", 64'(out_valid), 64'd0);
        repeat (10) tick();
        chk("err_sticky", 64'(err), 64'd1);

        // Zero-length descriptor
        base_issue = n_issue;
        set_desc(1, 11'h123, 0);
        pulse(2'b10);
        #1;
        chk("len0_busy", 64'(ch_busy), 64'd0);
        repeat (5) tick();
        chk("len0_issues", 64'(n_issue - base_issue), 64'd0);

        // Reset in the middle of a descriptor
        lat = 3;
        @(negedge clk);
        out_ready = 1'b0;
        set_desc(0, 11'h080, 8);
        push_desc(0, 11'h080, 8, 1'b1);
        pulse(2'b01);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_rd_en", 64'(ram_rd_en), 64'd0);
        chk("mid_rst_addr",  64'(ram_addr),  64'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data",  64'(out_data),  64'd0);
        chk("mid_rst_last",  64'(out_last),  64'd0);
        chk("mid_rst_busy",  64'(ch_busy),   64'd0);
        chk("mid_rst_err",   64'(err),       64'd0);
        exp_addr.delete();
        exp_q[0].delete();
        exp_q[1].delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        lat = 1;
        repeat (2) tick();
        set_desc(0, 11'h300, 2);
        push_desc(0, 11'h300, 2, 1'b1);
        pulse(2'b01);
        wait_idle("t7");
        chk("t7_err_clean", 64'(err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
